// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } RAM_ARBITER_STATE;

  localparam int unsigned RAM_ARBITER_PORT_FETCH = 0;
  localparam int unsigned RAM_ARBITER_PORT_DATA  = 1;

  function automatic logic [1:0] port_onehot(input logic index);
    return index ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and controller-side signals of the RAM arbiter, ports flattened as [i*W +: W].
interface ram_arbiter_if #(
  parameter int ADDRESS_SIZE = 28,
  parameter int DATA_SIZE    = 32,
  parameter int MASK_SIZE    = DATA_SIZE / 8
);
  logic [1:0]                req_valid;
  logic [1:0]                req_write;
  logic [2*ADDRESS_SIZE-1:0] req_address;
  logic [2*MASK_SIZE-1:0]    req_mask;
  logic [2*DATA_SIZE-1:0]    req_wdata;
  logic [1:0]                req_ready;
  logic [1:0]                resp_valid;
  logic [DATA_SIZE-1:0]      resp_rdata;
  logic                      resp_error;
  logic [ADDRESS_SIZE-1:0]   mem_address;
  logic [MASK_SIZE-1:0]      mem_mask;
  logic [DATA_SIZE-1:0]      mem_write_value;
  logic                      mem_write_trigger;
  logic                      mem_read_trigger;
  logic                      mem_ready;
  logic [DATA_SIZE-1:0]      mem_read_value;
  logic [3:0]                mem_error;

  modport master (
    output req_valid, req_write, req_address, req_mask, req_wdata,
    output mem_ready, mem_read_value, mem_error,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_mask, mem_write_value, mem_write_trigger, mem_read_trigger
  );

  modport slave (
    input  req_valid, req_write, req_address, req_mask, req_wdata,
    input  mem_ready, mem_read_value, mem_error,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_mask, mem_write_value, mem_write_trigger, mem_read_trigger
  );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie the port that was not granted last wins.
module ram_arbiter_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_index
);
  assign grant_valid = |valid;
  assign grant_index = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-word DDR3 controller user port between fetch (port 0) and load/store (port 1).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_SIZE   = 28,
  parameter int DATA_SIZE      = 32,
  parameter int MASK_SIZE      = DATA_SIZE / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic        clk,
  input logic        rst_n,
  ram_arbiter_if.slave bus
);
  localparam int TimerW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  RAM_ARBITER_STATE        state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic                    write_q, write_d;
  logic [ADDRESS_SIZE-1:0] address_q, address_d;
  logic [MASK_SIZE-1:0]    mask_q, mask_d;
  logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
  logic [1:0]              req_ready_q, req_ready_d;
  logic [1:0]              resp_valid_q, resp_valid_d;
  logic [DATA_SIZE-1:0]    resp_rdata_q, resp_rdata_d;
  logic                    resp_error_q, resp_error_d;
  logic                    wtrig_q, wtrig_d;
  logic                    rtrig_q, rtrig_d;

  logic grant_valid;
  logic grant_index;
  logic sel_write;

  ram_arbiter_rr_pick u_rr_pick (
    .valid       (bus.req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  assign sel_write = grant_index ? bus.req_write[1] : bus.req_write[0];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    write_d      = write_q;
    address_d    = address_q;
    mask_d       = mask_q;
    wdata_d      = wdata_q;
    req_ready_d  = 2'b00;
    resp_valid_d = 2'b00;
    resp_rdata_d = '0;
    resp_error_d = 1'b0;
    wtrig_d      = 1'b0;
    rtrig_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gate on mem_ready so a controller still busy after a timeout or reset is never re-triggered.
        if (bus.mem_ready && grant_valid) begin
          owner_d      = grant_index;
          last_grant_d = grant_index;
          write_d      = sel_write;
          address_d    = grant_index ? bus.req_address[2*ADDRESS_SIZE-1:ADDRESS_SIZE]
                                     : bus.req_address[ADDRESS_SIZE-1:0];
          mask_d       = grant_index ? bus.req_mask[2*MASK_SIZE-1:MASK_SIZE]
                                     : bus.req_mask[MASK_SIZE-1:0];
          wdata_d      = grant_index ? bus.req_wdata[2*DATA_SIZE-1:DATA_SIZE]
                                     : bus.req_wdata[DATA_SIZE-1:0];
          req_ready_d  = port_onehot(grant_index);
          wtrig_d      = sel_write;
          rtrig_d      = ~sel_write;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (bus.mem_ready) begin
          resp_valid_d = port_onehot(owner_q);
          resp_rdata_d = write_q ? '0 : bus.mem_read_value;
          resp_error_d = |bus.mem_error;
          state_d      = StResp;
        end else if (timer_q == TimerLast) begin
          resp_valid_d = port_onehot(owner_q);
          resp_error_d = 1'b1;
          state_d      = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      write_q      <= 1'b0;
      address_q    <= '0;
      mask_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 2'b00;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      wtrig_q      <= 1'b0;
      rtrig_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      write_q      <= write_d;
      address_q    <= address_d;
      mask_q       <= mask_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      wtrig_q      <= wtrig_d;
      rtrig_q      <= rtrig_d;
    end
  end

  assign bus.req_ready         = req_ready_q;
  assign bus.resp_valid        = resp_valid_q;
  assign bus.resp_rdata        = resp_rdata_q;
  assign bus.resp_error        = resp_error_q;
  assign bus.mem_address       = address_q;
  assign bus.mem_mask          = mask_q;
  assign bus.mem_write_value   = wdata_q;
  assign bus.mem_write_trigger = wtrig_q;
  assign bus.mem_read_trigger  = rtrig_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_ram_arbiter;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  // Model state: pending requests per port and the last granted port.
  bit [1:0]        pend;
  bit              last;
  bit              p_write [2];
  logic [AW-1:0]   p_addr  [2];
  logic [MW-1:0]   p_mask  [2];
  logic [DW-1:0]   p_wdata [2];

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MASK_SIZE(MW)) bus ();

  ram_arbiter #(
    .ADDRESS_SIZE   (AW),
    .DATA_SIZE      (DW),
    .MASK_SIZE      (MW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_ref(input bit [1:0] p, input bit lg);
    if (p == 2'b11) return lg ? 0 : 1;
    return p[1] ? 1 : 0;
  endfunction

  function automatic logic outputs_any();
    return |{bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_error,
             bus.mem_write_trigger, bus.mem_read_trigger, bus.mem_address,
             bus.mem_mask, bus.mem_write_value};
  endfunction

  task automatic post_req(input int i, input bit w, input logic [AW-1:0] a,
                          input logic [MW-1:0] m, input logic [DW-1:0] d);
    p_write[i] = w;
    p_addr[i]  = a;
    p_mask[i]  = m;
    p_wdata[i] = d;
    bus.req_valid[i]            = 1'b1;
    bus.req_write[i]            = w;
    bus.req_address[i*AW +: AW] = a;
    bus.req_mask[i*MW +: MW]    = m;
    bus.req_wdata[i*DW +: DW]   = d;
    pend[i] = 1'b1;
  endtask

  task automatic post_rand(input int i);
    post_req(i, 1'($urandom_range(0, 1)), AW'($urandom), MW'($urandom), $urandom);
  endtask

  // One grant/response cycle; DUT must be idle with mem_ready=1 and pend nonzero on entry.
  task automatic serve(input int lat, input bit tmo, input logic [DW-1:0] rv,
                       input logic [3:0] err, input bit inject, output int o);
    logic [1:0] oh;
    bit         early;
    int         n;
    o  = rr_ref(pend, last);
    oh = (o == 1) ? 2'b10 : 2'b01;
    step();
    check_eq("req_ready", bus.req_ready, oh);
    check_eq("trigger", {bus.mem_write_trigger, bus.mem_read_trigger},
             p_write[o] ? 2'b10 : 2'b01);
    check_eq("mem_address", bus.mem_address, p_addr[o]);
    check_eq("mem_mask", bus.mem_mask, p_mask[o]);
    check_eq("mem_write_value", bus.mem_write_value, p_wdata[o]);
    bus.req_valid[o] = 1'b0;
    pend[o]          = 1'b0;
    last             = (o == 1);
    bus.mem_ready    = 1'b0;
    early = 1'b0;
    n     = tmo ? TO : lat;
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 1)
        check_eq("pulse_width", {bus.req_ready, bus.mem_write_trigger, bus.mem_read_trigger}, 0);
      if (bus.resp_valid != 2'b00) early = 1'b1;
      if (inject && k == 2 && !pend[1-o]) post_rand(1 - o);
      if (!tmo && k == n) begin
        bus.mem_ready      = 1'b1;
        bus.mem_read_value = rv;
        bus.mem_error      = err;
      end
    end
    check_eq("no_early_resp", early, 0);
    step();
    check_eq("resp_valid", bus.resp_valid, oh);
    check_eq("resp_rdata", bus.resp_rdata, (tmo || p_write[o]) ? '0 : rv);
    check_eq("resp_error", bus.resp_error, tmo ? 1 : (err != 4'h0));
    check_eq("hold_address", bus.mem_address, p_addr[o]);
    check_eq("hold_wdata", {bus.mem_mask, bus.mem_write_value}, {p_mask[o], p_wdata[o]});
    bus.mem_error      = 4'h0;
    bus.mem_read_value = $urandom;
    step();
    check_eq("idle_gap", {bus.req_ready, bus.mem_write_trigger, bus.mem_read_trigger,
                          bus.resp_valid}, 0);
  endtask

  task automatic hold_no_grant(input int cycles);
    bit seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (bus.req_ready != 2'b00 || bus.mem_read_trigger || bus.mem_write_trigger) seen = 1'b1;
    end
    check_eq("no_grant_without_ready", seen, 0);
  endtask

  initial begin
    int  o;
    bit  tmo;
    bit  seen;
    logic [3:0] err;
    bus.req_valid      = '0;
    bus.req_write      = '0;
    bus.req_address    = '0;
    bus.req_mask       = '0;
    bus.req_wdata      = '0;
    bus.mem_ready      = 1'b1;
    bus.mem_read_value = '0;
    bus.mem_error      = 4'h0;
    pend = 2'b00;
    last = 1'b1;

    #1 rst_n = 1'b0;
    #1 check_eq("reset_outputs", outputs_any(), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Simultaneous requests alternate starting with port 0.
    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) post_rand(0);
      if (!pend[1]) post_rand(1);
      serve($urandom_range(1, 4), 1'b0, $urandom, 4'h0, 1'b0, o);
      check_eq("tie_order", o, i % 2);
    end
    serve(2, 1'b0, $urandom, 4'h0, 1'b0, o);

    post_req(0, 1'b0, 28'h0000010, 4'hF, 32'h0);
    serve(5, 1'b0, 32'hDEADBEEF, 4'h0, 1'b0, o);

    post_req(1, 1'b1, 28'h0000020, 4'hF, 32'h12345678);
    serve(3, 1'b0, 32'hCAFEF00D, 4'h0, 1'b0, o);

    post_req(0, 1'b0, AW'($urandom), 4'hF, 32'h0);
    serve(2, 1'b0, 32'h00000055, 4'h1, 1'b0, o);

    // Timeout, with port 1 arriving mid-wait; it must stay pending until mem_ready returns.
    post_rand(0);
    serve(1, 1'b1, 32'h0, 4'h0, 1'b1, o);
    check_eq("pending_after_timeout", pend, 2'b10);
    hold_no_grant(4);
    bus.mem_ready = 1'b1;
    serve(2, 1'b0, $urandom, 4'h0, 1'b0, o);

    // Reset during WAIT: outputs clear at once and no stale response follows.
    post_rand(0);
    step();
    bus.mem_ready = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1 check_eq("reset_mid_wait", outputs_any(), 0);
    bus.req_valid = '0;
    pend = 2'b00;
    last = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.resp_valid != 2'b00 || bus.req_ready != 2'b00) seen = 1'b1;
    end
    check_eq("no_stale_resp", seen, 0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) post_rand(i);
      if (pend == 2'b00) post_rand($urandom_range(0, 1));
      tmo = ($urandom_range(0, 7) == 0);
      err = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      serve($urandom_range(1, 6), tmo, $urandom, err, 1'($urandom_range(0, 1)), o);
      if (tmo) begin
        if (pend == 2'b00) post_rand($urandom_range(0, 1));
        hold_no_grant(2);
        bus.mem_ready = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end

endmodule
